// File: rtl/rgb_led_array_pwm_if.sv
// Control and LED-output bundle for the RGB LED array PWM driver.
// The master side drives the pattern controls; the slave side is the driver.
interface rgb_led_array_pwm_if #(
  parameter int P_LED_NUM = 4,
  parameter int P_DUTY_W  = 8,
  parameter int P_SPD_W   = 10
);
  logic [1:0]           I_MODE;
  logic [P_SPD_W-1:0]   I_SPEED;
  logic [P_DUTY_W-1:0]  I_BRIGHTNESS;
  logic                 I_INVERTED;
  logic [P_DUTY_W-1:0]  I_FIX_R;
  logic [P_DUTY_W-1:0]  I_FIX_G;
  logic [P_DUTY_W-1:0]  I_FIX_B;
  logic [P_LED_NUM-1:0] O_LED_R;
  logic [P_LED_NUM-1:0] O_LED_G;
  logic [P_LED_NUM-1:0] O_LED_B;
  logic                 O_FRAME;
  logic [3:0]           O_STATUS;

  modport master (
    output I_MODE, I_SPEED, I_BRIGHTNESS, I_INVERTED, I_FIX_R, I_FIX_G, I_FIX_B,
    input  O_LED_R, O_LED_G, O_LED_B, O_FRAME, O_STATUS
  );

  modport slave (
    input  I_MODE, I_SPEED, I_BRIGHTNESS, I_INVERTED, I_FIX_R, I_FIX_G, I_FIX_B,
    output O_LED_R, O_LED_G, O_LED_B, O_FRAME, O_STATUS
  );
endinterface

// File: rtl/rgb_led_array_pwm.sv
// Multi-LED RGB PWM driver: clock-enable divider, pattern sequencer
// (rainbow / fixed / breathing / blink), brightness scaler and PWM
// generators whose duty only changes on a period boundary.
module rgb_led_array_pwm #(
  parameter int P_LED_NUM = 4,
  parameter int P_DUTY_W  = 8,
  parameter int P_CE_DIV  = 10000,
  parameter int P_CE_W    = 14,
  parameter int P_SPD_W   = 10,
  parameter int P_PHASE   = 192
) (
  input  logic               I_CLK_100MHZ,
  input  logic               I_RST,
  rgb_led_array_pwm_if.slave bus
);

  localparam int HUE_W = P_DUTY_W + 2;
  localparam int HUE_N = 3 * (1 << P_DUTY_W);
  localparam logic [P_DUTY_W-1:0] MAX       = P_DUTY_W'((1 << P_DUTY_W) - 1);
  localparam logic [P_DUTY_W-1:0] MAX_M1    = P_DUTY_W'((1 << P_DUTY_W) - 2);
  localparam logic [HUE_W-1:0]    HUE_TOP   = HUE_W'(HUE_N - 1);
  localparam logic [P_CE_W-1:0]   CE_LAST   = P_CE_W'(P_CE_DIV - 1);

  typedef logic [P_LED_NUM-1:0][P_DUTY_W-1:0] duty_arr_t;

  logic [P_CE_W-1:0]   ce_cnt_r;
  logic                ce_s;
  logic [P_DUTY_W-1:0] pwm_cnt_r;
  logic                frame_s;
  logic [P_SPD_W-1:0]  step_cnt_r;
  logic [P_SPD_W:0]    step_nxt_s;
  logic                step_s;
  logic [HUE_W-1:0]    hue_r;
  logic [P_DUTY_W-1:0] level_r;
  logic                dir_down_r;
  logic                blink_r;
  logic [1:0]          mode_r;
  logic                mode_enter_s;
  duty_arr_t           col_r_s, col_g_s, col_b_s;
  duty_arr_t           nxt_r_r, nxt_g_r, nxt_b_r;
  duty_arr_t           act_r_r, act_g_r, act_b_r;
  logic [P_LED_NUM-1:0] led_r_r, led_g_r, led_b_r;
  logic                frame_r;

  // (c * (k + 1)) >> P_DUTY_W, used for both breathing and brightness
  function automatic logic [P_DUTY_W-1:0] scale(input logic [P_DUTY_W-1:0] c,
                                                input logic [P_DUTY_W-1:0] k);
    logic [2*P_DUTY_W-1:0] prod;
    prod = {{P_DUTY_W{1'b0}}, c} *
           {{(P_DUTY_W-1){1'b0}}, ({1'b0, k} + {{P_DUTY_W{1'b0}}, 1'b1})};
    return P_DUTY_W'(prod >> P_DUTY_W);
  endfunction

  // Hue of LED idx: base hue plus a fixed per-LED offset, wrapped once
  function automatic logic [HUE_W-1:0] led_hue(input logic [HUE_W-1:0] hue, input int idx);
    int sum;
    sum = int'(hue) + ((idx * P_PHASE) % HUE_N);
    return HUE_W'((sum >= HUE_N) ? (sum - HUE_N) : sum);
  endfunction

  // Three-segment colour wheel, returned as {R, G, B}
  function automatic logic [3*P_DUTY_W-1:0] rainbow(input logic [HUE_W-1:0] h);
    logic [P_DUTY_W-1:0] f;
    logic [1:0]          seg;
    f   = h[P_DUTY_W-1:0];
    seg = h[HUE_W-1:P_DUTY_W];
    case (seg)
      2'd0:    return {MAX - f, f, {P_DUTY_W{1'b0}}};
      2'd1:    return {{P_DUTY_W{1'b0}}, MAX - f, f};
      2'd2:    return {f, {P_DUTY_W{1'b0}}, MAX - f};
      default: return {(3*P_DUTY_W){1'b0}};
    endcase
  endfunction

  assign ce_s         = (ce_cnt_r == CE_LAST);
  assign frame_s      = ce_s && (pwm_cnt_r == MAX_M1);
  assign step_nxt_s   = {1'b0, step_cnt_r} + {{P_SPD_W{1'b0}}, 1'b1};
  assign step_s       = ce_s && (bus.I_SPEED != {P_SPD_W{1'b0}}) &&
                        (step_nxt_s >= {1'b0, bus.I_SPEED});
  assign mode_enter_s = frame_s && (bus.I_MODE != mode_r) && bus.I_MODE[1];

  // Clock-enable divider counting 0..P_CE_DIV-1
  always_ff @(posedge I_CLK_100MHZ or posedge I_RST) begin
    if (I_RST)     ce_cnt_r <= {P_CE_W{1'b0}};
    else if (ce_s) ce_cnt_r <= {P_CE_W{1'b0}};
    else           ce_cnt_r <= ce_cnt_r + {{(P_CE_W-1){1'b0}}, 1'b1};
  end

  // PWM period counter, MAX ticks per period
  always_ff @(posedge I_CLK_100MHZ or posedge I_RST) begin
    if (I_RST)        pwm_cnt_r <= {P_DUTY_W{1'b0}};
    else if (frame_s) pwm_cnt_r <= {P_DUTY_W{1'b0}};
    else if (ce_s)    pwm_cnt_r <= pwm_cnt_r + {{(P_DUTY_W-1){1'b0}}, 1'b1};
    else              pwm_cnt_r <= pwm_cnt_r;
  end

  // Step pacing: a step every I_SPEED ticks, frozen when I_SPEED is zero
  always_ff @(posedge I_CLK_100MHZ or posedge I_RST) begin
    if (I_RST)        step_cnt_r <= {P_SPD_W{1'b0}};
    else if (step_s)  step_cnt_r <= {P_SPD_W{1'b0}};
    else if (ce_s && (bus.I_SPEED != {P_SPD_W{1'b0}}))
                      step_cnt_r <= step_nxt_s[P_SPD_W-1:0];
    else              step_cnt_r <= step_cnt_r;
  end

  // Hue walks around the wheel in either direction; never touched by mode changes
  always_ff @(posedge I_CLK_100MHZ or posedge I_RST) begin
    if (I_RST) begin
      hue_r <= {HUE_W{1'b0}};
    end else if (step_s) begin
      if (bus.I_INVERTED) hue_r <= (hue_r == {HUE_W{1'b0}}) ? HUE_TOP : hue_r - {{(HUE_W-1){1'b0}}, 1'b1};
      else                hue_r <= (hue_r == HUE_TOP) ? {HUE_W{1'b0}} : hue_r + {{(HUE_W-1){1'b0}}, 1'b1};
    end else begin
      hue_r <= hue_r;
    end
  end

  // Breathing triangle and blink flag; restarted when entering mode 2 or 3
  always_ff @(posedge I_CLK_100MHZ or posedge I_RST) begin
    if (I_RST) begin
      level_r    <= {P_DUTY_W{1'b0}};
      dir_down_r <= 1'b0;
      blink_r    <= 1'b0;
    end else if (mode_enter_s) begin
      level_r    <= {P_DUTY_W{1'b0}};
      dir_down_r <= 1'b0;
      blink_r    <= 1'b0;
    end else if (step_s) begin
      blink_r <= ~blink_r;
      if (!dir_down_r) begin
        if (level_r == MAX) begin
          dir_down_r <= 1'b1;
          level_r    <= MAX_M1;
        end else begin
          level_r    <= level_r + {{(P_DUTY_W-1){1'b0}}, 1'b1};
        end
      end else begin
        if (level_r == {P_DUTY_W{1'b0}}) begin
          dir_down_r <= 1'b0;
          level_r    <= {{(P_DUTY_W-1){1'b0}}, 1'b1};
        end else begin
          level_r    <= level_r - {{(P_DUTY_W-1){1'b0}}, 1'b1};
        end
      end
    end else begin
      level_r    <= level_r;
      dir_down_r <= dir_down_r;
      blink_r    <= blink_r;
    end
  end

  // Mode is only taken on a period boundary so a period never mixes patterns
  always_ff @(posedge I_CLK_100MHZ or posedge I_RST) begin
    if (I_RST)        mode_r <= 2'd0;
    else if (frame_s) mode_r <= bus.I_MODE;
    else              mode_r <= mode_r;
  end

  // Unscaled colour of each LED for the active pattern
  always_comb begin
    col_r_s = '0;
    col_g_s = '0;
    col_b_s = '0;
    for (int i = 0; i < P_LED_NUM; i++) begin
      case (mode_r)
        2'd0: {col_r_s[i], col_g_s[i], col_b_s[i]} = rainbow(led_hue(hue_r, i));
        2'd1: begin
          col_r_s[i] = bus.I_FIX_R;
          col_g_s[i] = bus.I_FIX_G;
          col_b_s[i] = bus.I_FIX_B;
        end
        2'd2: begin
          col_r_s[i] = scale(bus.I_FIX_R, level_r);
          col_g_s[i] = scale(bus.I_FIX_G, level_r);
          col_b_s[i] = scale(bus.I_FIX_B, level_r);
        end
        2'd3: begin
          if (blink_r) begin
            col_r_s[i] = bus.I_FIX_R;
            col_g_s[i] = bus.I_FIX_G;
            col_b_s[i] = bus.I_FIX_B;
          end else begin
            col_r_s[i] = {P_DUTY_W{1'b0}};
            col_g_s[i] = {P_DUTY_W{1'b0}};
            col_b_s[i] = {P_DUTY_W{1'b0}};
          end
        end
        default: begin
          col_r_s[i] = {P_DUTY_W{1'b0}};
          col_g_s[i] = {P_DUTY_W{1'b0}};
          col_b_s[i] = {P_DUTY_W{1'b0}};
        end
      endcase
    end
  end

  // Next-duty stage: brightness-scaled colour, refreshed every clock
  always_ff @(posedge I_CLK_100MHZ or posedge I_RST) begin
    if (I_RST) begin
      nxt_r_r <= '0;
      nxt_g_r <= '0;
      nxt_b_r <= '0;
    end else begin
      for (int i = 0; i < P_LED_NUM; i++) begin
        nxt_r_r[i] <= scale(col_r_s[i], bus.I_BRIGHTNESS);
        nxt_g_r[i] <= scale(col_g_s[i], bus.I_BRIGHTNESS);
        nxt_b_r[i] <= scale(col_b_s[i], bus.I_BRIGHTNESS);
      end
    end
  end

  // Active duty is swapped in only at the period boundary (glitch-free PWM)
  always_ff @(posedge I_CLK_100MHZ or posedge I_RST) begin
    if (I_RST) begin
      act_r_r <= '0;
      act_g_r <= '0;
      act_b_r <= '0;
    end else if (frame_s) begin
      act_r_r <= nxt_r_r;
      act_g_r <= nxt_g_r;
      act_b_r <= nxt_b_r;
    end else begin
      act_r_r <= act_r_r;
      act_g_r <= act_g_r;
      act_b_r <= act_b_r;
    end
  end

  // Registered PWM comparators and frame pulse
  always_ff @(posedge I_CLK_100MHZ or posedge I_RST) begin
    if (I_RST) begin
      led_r_r <= {P_LED_NUM{1'b0}};
      led_g_r <= {P_LED_NUM{1'b0}};
      led_b_r <= {P_LED_NUM{1'b0}};
      frame_r <= 1'b0;
    end else begin
      for (int i = 0; i < P_LED_NUM; i++) begin
        led_r_r[i] <= (pwm_cnt_r < act_r_r[i]);
        led_g_r[i] <= (pwm_cnt_r < act_g_r[i]);
        led_b_r[i] <= (pwm_cnt_r < act_b_r[i]);
      end
      frame_r <= frame_s;
    end
  end

  assign bus.O_LED_R  = led_r_r;
  assign bus.O_LED_G  = led_g_r;
  assign bus.O_LED_B  = led_b_r;
  assign bus.O_FRAME  = frame_r;
  assign bus.O_STATUS = {mode_r, bus.I_INVERTED, I_RST};

endmodule

// File: tb/tb_rgb_led_array_pwm.sv
// Scoreboard bench for rgb_led_array_pwm. Expected per-period duties come
// from a closed-form model (step count as a function of elapsed ticks).
module tb_rgb_led_array_pwm;
  localparam int LN = 4, DW = 8, CED = 4, CEW = 14, SW = 10, PH = 192;
  localparam int MAXV = 255, HN = 768, PERIOD = MAXV * CED;

  typedef struct packed {
    logic [1:0]              mode;
    logic [3*LN-1:0][7:0]    duty;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rgb_led_array_pwm_if #(.P_LED_NUM(LN), .P_DUTY_W(DW), .P_SPD_W(SW)) bus ();

  rgb_led_array_pwm #(
    .P_LED_NUM(LN), .P_DUTY_W(DW), .P_CE_DIV(CED), .P_CE_W(CEW),
    .P_SPD_W(SW), .P_PHASE(PH)
  ) dut (
    .I_CLK_100MHZ(clk),
    .I_RST       (rst),
    .bus         (bus)
  );

  int tests = 0;
  int fails = 0;
  exp_t exp_q[$];
  int frame_cnt = 0;

  int sc_mode_a, sc_mode_b, sc_chg, sc_speed, sc_inv, sc_bri;
  int sc_fix[3];

  task automatic check(input string nm, input int act, input int expv);
    tests++;
    if (act != expv) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  // I_MODE value taken at frame j (frame 0 = reset value)
  function automatic int mode_in(input int j);
    if (j < 1) return 0;
    return (sc_chg != 0 && j >= sc_chg) ? sc_mode_b : sc_mode_a;
  endfunction

  // number of steps issued at ce ticks 1..n
  function automatic int steps_upto(input int n);
    return (sc_speed == 0) ? 0 : n / sc_speed;
  endfunction

  // expected duties of the period that starts at frame k
  function automatic exp_t model(input int k);
    exp_t e;
    int m, s_cnt, hue, t, p, lvl, blk, h, f, seg, raw;
    int c[3];
    e = '0;
    m = mode_in(k - 1);
    s_cnt = steps_upto(MAXV * k - 1);
    hue = sc_inv ? (HN - (s_cnt % HN)) % HN : s_cnt % HN;
    t = s_cnt;
    for (int j = 1; j < k; j++)
      if (mode_in(j) != mode_in(j - 1) && mode_in(j) >= 2) t = s_cnt - steps_upto(MAXV * j);
    p = t % 510;
    lvl = (p <= 255) ? p : 510 - p;
    blk = t % 2;
    for (int i = 0; i < LN; i++) begin
      h = (hue + i * PH) % HN;
      f = h % 256;
      seg = h / 256;
      if (seg == 0)      begin c[0] = 255 - f; c[1] = f;       c[2] = 0;       end
      else if (seg == 1) begin c[0] = 0;       c[1] = 255 - f; c[2] = f;       end
      else               begin c[0] = f;       c[1] = 0;       c[2] = 255 - f; end
      for (int ch = 0; ch < 3; ch++) begin
        case (m)
          0: raw = c[ch];
          1: raw = sc_fix[ch];
          2: raw = (sc_fix[ch] * (lvl + 1)) / 256;
          default: raw = blk ? sc_fix[ch] : 0;
        endcase
        e.duty[ch*LN + i] = 8'((raw * (sc_bri + 1)) / 256);
      end
    end
    e.mode = 2'(mode_in(k + 1));
    return e;
  endfunction

  // Monitor: measures each full PWM period between O_FRAME pulses
  int hi[3*LN];
  int samples;
  bit have_frame;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      samples = 0;
      have_frame = 0;
      frame_cnt = 0;
      for (int i = 0; i < 3*LN; i++) hi[i] = 0;
    end else begin
      samples++;
      for (int i = 0; i < LN; i++) begin
        hi[i]        += int'(bus.O_LED_R[i]);
        hi[LN + i]   += int'(bus.O_LED_G[i]);
        hi[2*LN + i] += int'(bus.O_LED_B[i]);
      end
      if (bus.O_FRAME) begin
        if (have_frame) begin
          check("frame_period", samples, PERIOD);
          if (exp_q.size() == 0) begin
            check("sb_underflow", 1, 0);
          end else begin
            e = exp_q.pop_front();
            for (int i = 0; i < 3*LN; i++)
              check($sformatf("duty_f%0d_ch%0d_led%0d", frame_cnt, i / LN, i % LN),
                    hi[i], CED * int'(e.duty[i]));
            check($sformatf("status_mode_f%0d", frame_cnt + 1), int'(bus.O_STATUS[3:2]), int'(e.mode));
          end
        end
        have_frame = 1;
        samples = 0;
        frame_cnt++;
        for (int i = 0; i < 3*LN; i++) hi[i] = 0;
      end
    end
  end

  task automatic set_scn(input int ma, input int mb, input int chg, input int spd,
                         input int inv, input int fr, input int fg, input int fb, input int bri);
    sc_mode_a = ma; sc_mode_b = mb; sc_chg = chg; sc_speed = spd; sc_inv = inv;
    sc_fix[0] = fr; sc_fix[1] = fg; sc_fix[2] = fb; sc_bri = bri;
  endtask

  task automatic wait_frames(input int target, input int budget, input string nm);
    int n;
    n = 0;
    while (frame_cnt < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (frame_cnt < target) check(nm, frame_cnt, target);
  endtask

  task automatic check_reset_outputs(input string nm);
    check({nm, "_led_r"}, int'(bus.O_LED_R), 0);
    check({nm, "_led_g"}, int'(bus.O_LED_G), 0);
    check({nm, "_led_b"}, int'(bus.O_LED_B), 0);
    check({nm, "_frame"}, int'(bus.O_FRAME), 0);
    check({nm, "_status0"}, int'(bus.O_STATUS[0]), 1);
  endtask

  // One scenario: starts in reset, runs K frames, ends with a mid-period reset
  task automatic run_scn(input int k_frames);
    int n;
    bus.I_MODE       = 2'(sc_mode_a);
    bus.I_SPEED      = SW'(sc_speed);
    bus.I_INVERTED   = sc_inv[0];
    bus.I_FIX_R      = 8'(sc_fix[0]);
    bus.I_FIX_G      = 8'(sc_fix[1]);
    bus.I_FIX_B      = 8'(sc_fix[2]);
    bus.I_BRIGHTNESS = 8'(sc_bri);
    exp_q.delete();
    for (int k = 1; k < k_frames; k++) exp_q.push_back(model(k));
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.O_FRAME && n < 2 * PERIOD);
    check("first_frame_latency", n, PERIOD);
    if (sc_chg >= 2) begin
      wait_frames(sc_chg - 1, 2 * PERIOD, "wait_chg_frame");
      repeat (500) @(negedge clk);
      bus.I_MODE = 2'(sc_mode_b);
    end
    wait_frames(k_frames, (k_frames + 1) * PERIOD, "wait_frames_timeout");
    check("sb_drained", exp_q.size(), 0);
    repeat (300) @(negedge clk);
    #2 rst = 1'b1;
    #1 check_reset_outputs("async_reset");
    check("async_reset_mode", int'(bus.O_STATUS[3:2]), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    set_scn(0, 0, 0, 1, 0, 0, 0, 0, 255);
    bus.I_MODE = 2'd0; bus.I_SPEED = SW'(1); bus.I_INVERTED = 1'b0;
    bus.I_FIX_R = 8'd0; bus.I_FIX_G = 8'd0; bus.I_FIX_B = 8'd0;
    bus.I_BRIGHTNESS = 8'd255;
    #2;
    check_reset_outputs("reset_state");
    check("reset_status", int'(bus.O_STATUS), 1);
    repeat (3) @(negedge clk);

    set_scn(1, 1, 0, 1, 0, 128, 0, 255, 255); run_scn(3);   // fixed colour
    set_scn(0, 0, 0, 1, 0, 0, 0, 0, 255);     run_scn(5);   // rainbow, hue wraps
    set_scn(0, 0, 0, 1, 1, 0, 0, 0, 255);     run_scn(3);   // rainbow, inverted
    set_scn(0, 0, 0, 0, 0, 0, 0, 0, 255);     run_scn(4);   // frozen pattern
    set_scn(2, 2, 0, 2, 0, 255, 255, 255, 255); run_scn(4); // breathing peak
    set_scn(1, 1, 0, 1, 0, 200, 200, 200, 127); run_scn(3); // brightness scaling
    set_scn(1, 2, 3, 3, 0, $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 255), 255);     run_scn(5);   // mid-period mode change
    set_scn(3, 3, 0, 1, 0, 90, 180, 255, 255); run_scn(3);  // blink
    for (int r = 0; r < 5; r++) begin
      set_scn($urandom_range(0, 3), $urandom_range(0, 3),
              ($urandom_range(0, 1) == 0) ? 0 : 2 + $urandom_range(0, 1),
              $urandom_range(0, 20), $urandom_range(0, 1),
              $urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
              $urandom_range(0, 255));
      run_scn(4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
